// File: rtl/ref_level_gen_win_pkg.sv
// ref_level_gen_win_pkg: shared widths, mode encodings and the 1sX product-extract helper
package ref_level_gen_win_pkg;
  localparam int DATA_W_DEF = 18;
  localparam int MODE_BLOCK = 0;
  localparam int MODE_LEAKY = 1;
endpackage

// Top W bits of a 2W-bit 1sX*1sX product, i.e. p[2W-2 -: W] written as a shift.
`define FX_1SX(p, w) ((w)'((p) >> ((w) - 1)))

// File: rtl/ref_level_gen_win_sat_abs.sv
// sat_abs: saturating two's-complement magnitude, signed W-bit in, unsigned W-1-bit out
//   i_d   signed input
//   o_mag |i_d|, the most negative input saturates to 2^(W-1)-1
module sat_abs #(
  parameter int W = 18
) (
  input  logic signed [W-1:0] i_d,
  output logic        [W-2:0] o_mag
);
  logic [W-1:0] w_neg;
  assign w_neg = -i_d;
  // Negating the most negative value leaves its sign bit set, which flags the saturation case.
  assign o_mag = i_d[W-1] ? (w_neg[W-1] ? '1 : w_neg[W-2:0]) : i_d[W-2:0];
endmodule

// File: rtl/ref_level_gen_win.sv
// ref_level_gen_win: slicer reference level (windowed or leaky |dec_var| average) plus average power
//   clk, reset        clock, synchronous active-high reset
//   clk_en, hold      symbol strobe and sample freeze
//   dec_var           signed decision variable
//   ref_level/_valid  averaged magnitude and its update pulse
//   avg_power/_valid  ref_level^2 * POWER_SCALE, two clocks after ref_valid
module ref_level_gen_win
  import ref_level_gen_win_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LOG_LEN     = 8,
  parameter int MODE        = MODE_BLOCK,
  parameter int POWER_SCALE = 65536
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic                     hold,
  input  logic signed [DATA_W-1:0] dec_var,
  output logic signed [DATA_W-1:0] ref_level,
  output logic                     ref_valid,
  output logic signed [DATA_W-1:0] avg_power,
  output logic                     power_valid
);
  localparam int AW = DATA_W - 1 + LOG_LEN;
  localparam logic [DATA_W-1:0] PS = DATA_W'(POWER_SCALE);
  logic              w_take;
  logic [DATA_W-2:0] w_mag;
  logic [DATA_W-2:0] r_mag;
  logic              r_mag_vld;
  logic [AW-1:0]     r_acc;
  logic [AW-1:0]     w_ext;
  logic [AW-1:0]     w_blk;
  logic [AW-1:0]     w_lky;
  logic [LOG_LEN-1:0] r_cnt;
  logic [DATA_W-1:0] r_sq_t;
  logic              r_sq_vld;
  assign w_take = clk_en & ~hold & ~reset;
  sat_abs #(.W(DATA_W)) u_abs (.i_d(dec_var), .o_mag(w_mag));
  assign w_ext = {{LOG_LEN{1'b0}}, r_mag};
  assign w_blk = r_acc + w_ext;
  // Leaky steady state is 2^LOG_LEN * mag, so this never exceeds AW bits.
  assign w_lky = r_acc - (r_acc >> LOG_LEN) + w_ext;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mag       <= '0;
      r_mag_vld   <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      ref_level   <= '0;
      ref_valid   <= 1'b0;
      r_sq_t      <= '0;
      r_sq_vld    <= 1'b0;
      avg_power   <= '0;
      power_valid <= 1'b0;
    end else begin
      r_mag_vld   <= w_take;
      ref_valid   <= 1'b0;
      r_sq_vld    <= ref_valid;
      power_valid <= r_sq_vld;
      if (w_take) r_mag <= w_mag;
      if (ref_valid) r_sq_t <= `FX_1SX({{DATA_W{1'b0}}, ref_level} * {{DATA_W{1'b0}}, ref_level}, DATA_W);
      if (r_sq_vld) avg_power <= `FX_1SX({{DATA_W{1'b0}}, r_sq_t} * {{DATA_W{1'b0}}, PS}, DATA_W);
      // Driven by r_mag_vld rather than take so a mag registered just before hold/clk_en fell still lands.
      if (r_mag_vld) begin
        if (MODE == MODE_LEAKY) begin
          r_acc     <= w_lky;
          ref_level <= DATA_W'(w_lky >> LOG_LEN);
          ref_valid <= 1'b1;
        end else if (&r_cnt) begin
          r_acc     <= '0;
          r_cnt     <= '0;
          ref_level <= DATA_W'(w_blk >> LOG_LEN);
          ref_valid <= 1'b1;
        end else begin
          r_acc <= w_blk;
          r_cnt <= r_cnt + LOG_LEN'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_ref_level_gen_win.sv
// tb_ref_level_gen_win: scoreboard bench for block and leaky reference-level generators
module tb_ref_level_gen_win;
  typedef struct {
    int lvl;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en_b = 1'b0;
  logic en_l = 1'b0;
  logic hold = 1'b0;
  logic signed [17:0] dec_var = '0;
  logic signed [17:0] ref_level_b, avg_power_b, ref_level_l, avg_power_l;
  logic ref_valid_b, power_valid_b, ref_valid_l, power_valid_l;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_lv = 0;
  int last_l = 0;
  logic [1:0] rvb_d = '0;
  logic [1:0] rvl_d = '0;
  exp_t q_b[$];
  int qp_b[$];
  int q_l[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ref_level_gen_win #(.DATA_W(18), .LOG_LEN(2), .MODE(0), .POWER_SCALE(65536)) u_blk (
    .clk(clk), .reset(reset), .clk_en(en_b), .hold(hold), .dec_var(dec_var),
    .ref_level(ref_level_b), .ref_valid(ref_valid_b), .avg_power(avg_power_b), .power_valid(power_valid_b));
  ref_level_gen_win #(.DATA_W(18), .LOG_LEN(2), .MODE(1), .POWER_SCALE(65536)) u_lky (
    .clk(clk), .reset(reset), .clk_en(en_l), .hold(hold), .dec_var(dec_var),
    .ref_level(ref_level_l), .ref_valid(ref_valid_l), .avg_power(avg_power_l), .power_valid(power_valid_l));

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic smp(input logic signed [17:0] v, input logic eb, input logic el, input logic h);
    @(negedge clk);
    dec_var = v;
    en_b = eb;
    en_l = el;
    hold = h;
  endtask

  task automatic expect_blk(input int lvl, input int pow);
    q_b.push_back('{lvl: lvl, cyc: cyc + 2});
    qp_b.push_back(pow);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ref_level_b"}, ref_level_b, 0);
    chk({nm, "_ref_valid_b"}, ref_valid_b, 0);
    chk({nm, "_avg_power_b"}, avg_power_b, 0);
    chk({nm, "_power_valid_b"}, power_valid_b, 0);
    chk({nm, "_ref_level_l"}, ref_level_l, 0);
    chk({nm, "_ref_valid_l"}, ref_valid_l, 0);
    chk({nm, "_avg_power_l"}, avg_power_l, 0);
    chk({nm, "_power_valid_l"}, power_valid_l, 0);
  endtask

  always @(negedge clk) begin
    if (ref_valid_b) begin
      if (q_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL blk_unexpected_ref_valid: got ref_level=%0d expected no ref_valid", ref_level_b);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("blk_ref_level", ref_level_b, e.lvl);
        chk("blk_latency_cycle", cyc, e.cyc);
      end
    end
    if (power_valid_b) begin
      if (qp_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL blk_unexpected_power_valid: got avg_power=%0d expected no power_valid", avg_power_b);
      end else chk("blk_avg_power", avg_power_b, qp_b.pop_front());
    end
    if (power_valid_b | rvb_d[1]) chk("blk_power_timing", power_valid_b, rvb_d[1]);
    if (power_valid_l | rvl_d[1]) chk("lky_power_timing", power_valid_l, rvl_d[1]);
    if (ref_valid_l) begin
      n_lv++;
      if (q_l.size() != 0) chk("lky_ref_level", ref_level_l, q_l.pop_front());
      else chk("lky_monotonic", ref_level_l >= last_l, 1);
      last_l = ref_level_l;
    end
    rvb_d <= {rvb_d[0], ref_valid_b};
    rvl_d <= {rvl_d[0], ref_valid_l};
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    // block window of 4: constant +32768
    for (int i = 0; i < 8; i++) begin
      smp(18'sd32768, 1, 0, 0);
      if (i % 4 == 3) expect_blk(32768, 4096);
    end
    // negatives take the true magnitude
    for (int i = 0; i < 4; i++) begin
      smp(i % 2 ? 18'sd32768 : -18'sd32768, 1, 0, 0);
      if (i == 3) expect_blk(32768, 4096);
    end
    // most negative value saturates; 131071^2>>17=131070, *65536>>17=65535
    for (int i = 0; i < 4; i++) begin
      smp(-18'sd131072, 1, 0, 0);
      if (i == 3) expect_blk(131071, 65535);
    end
    // hold mid-window preserves the partial sum
    smp(18'sd100, 1, 0, 0);
    smp(18'sd200, 1, 0, 0);
    for (int i = 0; i < 5; i++) smp(18'($urandom), 1, 0, 1);
    smp(18'sd300, 1, 0, 0);
    smp(18'sd400, 1, 0, 0);
    expect_blk(250, 0);
    repeat (6) smp(18'sd0, 0, 0, 0);
    // reset mid-window discards the partial sum
    for (int i = 0; i < 3; i++) smp(18'sd40000, 1, 0, 0);
    @(negedge clk);
    en_b = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero("post_reset");
    for (int i = 0; i < 4; i++) begin
      smp(18'sd8, 1, 0, 0);
      if (i == 3) expect_blk(8, 0);
    end
    repeat (6) smp(18'sd0, 0, 0, 0);
    // leaky average, LOG_LEN=2, step 0 -> 1024
    q_l.push_back(0);
    q_l.push_back(0);
    q_l.push_back(256);
    q_l.push_back(448);
    q_l.push_back(592);
    q_l.push_back(700);
    for (int i = 0; i < 2; i++) smp(18'sd0, 0, 1, 0);
    for (int i = 0; i < 40; i++) smp(18'sd1024, 0, 1, 0);
    repeat (6) smp(18'sd0, 0, 0, 0);
    chk("lky_valid_count", n_lv, 42);
    chk("lky_converged", last_l >= 1020, 1);
    chk("lky_queue_drained", q_l.size(), 0);
    // sparse clk_en: one enabled sample every 8 clocks; 5000^2>>17=190, *65536>>17=95
    for (int k = 0; k < 4; k++) begin
      smp(18'sd5000, 1, 0, 0);
      if (k == 3) expect_blk(5000, 95);
      for (int i = 0; i < 7; i++) smp(18'($urandom), 0, 0, 0);
    end
    repeat (10) smp(18'sd0, 0, 0, 0);
    chk("blk_ref_queue_drained", q_b.size(), 0);
    chk("blk_power_queue_drained", qp_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
